// File: rtl/alu_pkg.sv
// Shared op-select codes and flag bit positions for the pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_TFR = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_n_pipe_core.sv
// Combinational ALU datapath: adder-based arithmetic and bitwise logic ops.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       S,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] G,
    output logic             Cout,
    output logic             V
);

    logic [WIDTH-1:0] bop;
    logic [WIDTH:0]   sum;

    always_comb begin
        bop  = '0;
        sum  = '0;
        G    = '0;
        Cout = 1'b0;
        V    = 1'b0;
        unique case (op_e'(S))
            OP_TFR: bop = '0;
            OP_ADD: bop = B;
            OP_SUB: bop = ~B;
            OP_DEC: bop = '1;
            OP_AND: G = A & B;
            OP_OR:  G = A | B;
            OP_XOR: G = A ^ B;
            OP_NOT: G = ~A;
        endcase
        // overflow: adder inputs agree in sign but the result does not
        if (!S[2]) begin
            sum  = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, Cin};
            G    = sum[WIDTH-1:0];
            Cout = sum[WIDTH];
            V    = (A[WIDTH-1] == bop[WIDTH-1]) &&
                   (G[WIDTH-1] != A[WIDTH-1]);
        end
    end

endmodule

// File: rtl/alu_n_pipe.sv
// Two-stage ALU pipeline with valid/ready handshakes and an accumulator.
module alu_n_pipe
    import alu_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] ACC_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       S,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ASEL,
    input  logic             ACC_WE,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] G,
    output logic             Cout,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ACC
);

    logic             s1_valid;
    logic [2:0]       s1_s;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_asel;
    logic             s1_we;

    logic             hold2;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [NFLAGS-1:0] flags_n;
    logic [NFLAGS-1:0] flags;

    assign hold2    = out_valid && !out_ready;
    assign in_ready = !(s1_valid && hold2);

    // accumulator is read at compute time, so chained ops need no bubble
    assign opa = s1_asel ? ACC : s1_a;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .S    (s1_s),
        .Cin  (s1_cin),
        .A    (opa),
        .B    (s1_b),
        .G    (res),
        .Cout (res_c),
        .V    (res_v)
    );

    always_comb begin
        flags_n         = '0;
        flags_n[FLAG_C] = res_c;
        flags_n[FLAG_Z] = (res == '0);
        flags_n[FLAG_N] = res[WIDTH-1];
        flags_n[FLAG_V] = res_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_s    <= S;
            s1_cin  <= Cin;
            s1_a    <= A;
            s1_b    <= B;
            s1_asel <= ASEL;
            s1_we   <= ACC_WE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            G         <= '0;
            flags     <= '0;
            ACC       <= ACC_RST;
        end else if (!hold2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                G     <= res;
                flags <= flags_n;
                if (s1_we) ACC <= res;
            end
        end
    end

    assign Cout = flags[FLAG_C];
    assign Z    = flags[FLAG_Z];
    assign N    = flags[FLAG_N];
    assign V    = flags[FLAG_V];

endmodule

// File: tb/tb_alu_n_pipe.sv
// Randomised and directed bench for alu_n_pipe against an arithmetic model.
module tb_alu_n_pipe;
    import alu_pkg::*;

    localparam logic [3:0] RST4 = 4'h6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] s = '0;
    logic       cin = 1'b0;
    logic [3:0] a = '0, b = '0;
    logic       asel = 1'b0, acc_we = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid;
    logic [3:0] g, acc;
    logic       cout, z, n, v;

    logic [2:0]  s32 = '0;
    logic        cin32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_valid32 = 1'b0, out_ready32 = 1'b1;
    logic        in_ready32, out_valid32;
    logic [31:0] g32, acc32;
    logic        cout32, z32, n32, v32;

    alu_n_pipe #(.WIDTH(4), .ACC_RST(RST4)) dut (
        .clk(clk), .rst(rst), .S(s), .Cin(cin), .A(a), .B(b),
        .ASEL(asel), .ACC_WE(acc_we),
        .in_valid(in_valid), .in_ready(in_ready),
        .G(g), .Cout(cout), .Z(z), .N(n), .V(v),
        .out_valid(out_valid), .out_ready(out_ready), .ACC(acc)
    );

    alu_n_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .S(s32), .Cin(cin32), .A(a32), .B(b32),
        .ASEL(1'b0), .ACC_WE(1'b0),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .G(g32), .Cout(cout32), .Z(z32), .N(n32), .V(v32),
        .out_valid(out_valid32), .out_ready(out_ready32), .ACC(acc32)
    );

    typedef struct {
        logic [3:0] g;
        bit         c, z, n, v;
        logic [3:0] acc;
    } exp_t;

    exp_t       exp_q[$];
    int         nchk = 0;
    int         nerr = 0;
    logic [3:0] macc = RST4;
    bit         held = 1'b0;
    logic [3:0] held_g = '0;
    bit         took = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference ALU from the op table, using signed range for overflow
    function automatic void ref_alu(input int w, input int op, input int ci,
                                    input longint ra, input longint rb,
                                    output longint rg, output bit rc,
                                    output bit rz, output bit rn,
                                    output bit rv);
        longint mask, half, o2, sum, sa, so, ss;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        if (op < 4) begin
            case (op)
                0:       o2 = 0;
                1:       o2 = rb;
                2:       o2 = mask - rb;
                default: o2 = mask;
            endcase
            sum = ra + o2 + ci;
            rg  = sum & mask;
            rc  = ((sum >> w) & 1) == 1;
            sa  = (ra >= half) ? ra - 2 * half : ra;
            so  = (o2 >= half) ? o2 - 2 * half : o2;
            ss  = sa + so + ci;
            rv  = (ss > half - 1) || (ss < -half);
        end else begin
            case (op)
                4:       rg = ra & rb;
                5:       rg = ra | rb;
                6:       rg = ra ^ rb;
                default: rg = mask & ~ra;
            endcase
            rc = 1'b0;
            rv = 1'b0;
        end
        rz = (rg == 0);
        rn = ((rg >> (w - 1)) & 1) == 1;
    endfunction

    task automatic step(input bit iv, input logic [2:0] is, input bit ic,
                        input logic [3:0] ia, input logic [3:0] ib,
                        input bit ias, input bit iwe, input bit ordy);
        exp_t       e;
        longint     gg;
        bit         rc, rz, rn, rv;
        logic [3:0] aop;
        @(negedge clk);
        in_valid  = iv;
        s         = is;
        cin       = ic;
        a         = ia;
        b         = ib;
        asel      = ias;
        acc_we    = iwe;
        out_ready = ordy;
        #1;
        if (held) begin
            chk("hold_ov", out_valid, 1);
            chk("hold_g", g, held_g);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("g", g, e.g);
                chk("cout", cout, e.c);
                chk("z", z, e.z);
                chk("n", n, e.n);
                chk("v", v, e.v);
                chk("acc", acc, e.acc);
            end
        end
        held   = out_valid && !out_ready;
        held_g = g;
        took   = iv && in_ready;
        if (took) begin
            aop = ias ? macc : ia;
            ref_alu(4, int'(is), int'(ic), longint'(aop), longint'(ib),
                    gg, rc, rz, rn, rv);
            if (iwe) macc = gg[3:0];
            e.g   = gg[3:0];
            e.c   = rc;
            e.z   = rz;
            e.n   = rn;
            e.v   = rv;
            e.acc = macc;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset(input bit iv);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = iv;
        s         = OP_ADD;
        a         = 4'h5;
        b         = 4'h5;
        acc_we    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        acc_we   = 1'b0;
        exp_q.delete();
        macc = RST4;
        held = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        repeat (2) @(posedge clk);
        do_reset(1'b1);
        chk("rst_ov", out_valid, 0);
        chk("rst_g", g, 0);
        chk("rst_flags", {cout, z, n, v}, 4'b0000);
        chk("rst_acc", acc, RST4);
        chk("rst_rdy", in_ready, 1);
        chk("rst_acc32", acc32, 0);

        step(1'b1, OP_ADD, 1'b0, 4'hF, 4'h1, 1'b0, 1'b0, 1'b1);
        idle();
        chk("lat_ov1", out_valid, 0);
        idle();
        chk("r033_ov", out_valid, 1);
        chk("r033_g", g, 4'h0);
        chk("r033_cz", {cout, z, v}, 3'b110);

        step(1'b1, OP_SUB, 1'b1, 4'h3, 4'h5, 1'b0, 1'b0, 1'b1);
        step(1'b1, OP_ADD, 1'b0, 4'h7, 4'h1, 1'b0, 1'b0, 1'b1);
        idle();
        chk("r034a_g", g, 4'hE);
        chk("r034a_cnv", {cout, n, v}, 3'b010);
        idle();
        chk("r034b_g", g, 4'h8);
        chk("r034b_v", v, 1);
        drain();

        for (int k = 0; k < 16; k++)
            step(1'b1, 3'(k >> 1), 1'(k & 1), 4'hF, 4'h1,
                 1'b0, 1'b0, 1'b1);
        drain();

        step(1'b1, OP_TFR, 1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, OP_ADD, 1'b0, 4'h0, 4'h3, 1'b1, 1'b1, 1'b1);
        drain();
        chk("chain_acc", acc, 4'hB);

        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(idx < 4, OP_ADD, 1'b0, 4'(idx + 1), 4'(idx * 3),
                 1'b0, 1'b0, 1'b0);
            if (took) idx++;
        end
        chk("stall_accepts", idx, 2);
        chk("stall_rdy", in_ready, 0);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step(1'b1, OP_ADD, 1'b0, 4'(idx + 1), 4'(idx * 3),
                 1'b0, 1'b0, 1'b1);
            if (took) idx++;
        end
        chk("stall_all", idx, 4);
        drain();

        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        drain();

        step(1'b1, OP_ADD, 1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b0);
        step(1'b1, OP_OR, 1'b0, 4'h9, 4'h4, 1'b0, 1'b1, 1'b0);
        do_reset(1'b1);
        chk("mid_ov", out_valid, 0);
        chk("mid_acc", acc, RST4);
        chk("mid_rdy", in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            idle();
            chk("no_stale", out_valid, 0);
        end
        chk("mid_acc_after", acc, RST4);

        @(negedge clk);
        in_valid32  = 1'b1;
        s32         = OP_ADD;
        cin32       = 1'b0;
        a32         = 32'hFFFF_FFFF;
        b32         = 32'h1;
        out_ready32 = 1'b1;
        @(negedge clk);
        in_valid32 = 1'b0;
        #1;
        chk("w32_lat", out_valid32, 0);
        @(negedge clk);
        #1;
        chk("w32_ov", out_valid32, 1);
        chk("w32_g", g32, 0);
        chk("w32_czv", {cout32, z32, v32}, 3'b110);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
